debug_step_controller: RTL and testbench

Clock-enable sequencer for the pipelined CPU on the FPGA board. It turns the board pushbuttons and the manual-mode switch into single-step, run/stop and free-run control of the pipeline, and stops execution on a fetch-PC breakpoint or a CPU halt. It also tells the HEX display sequencer when to refresh after a step, so the displayed PC, opcode and register values always match the stopped machine.

---
 rtl/debug_step_controller_if.sv | 32 +++
 rtl/debug_step_controller.sv | 143 ++++++++++++++
 tb/tb_debug_step_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/debug_step_controller_if.sv
// Board-side bundle of debug_step_controller: buttons, breakpoint
// inputs, CPU hooks and the status outputs that feed the HEX display.
interface debug_step_controller_if #(
    parameter int CNT_W = 16
);
    logic             key_step_n;
    logic             key_run_n;
    logic             manual_mode;
    logic             bp_en;
    logic [6:0]       bp_pc;
    logic [6:0]       pc_fetch;
    logic             cpu_halt;
    logic             cpu_en;
    logic [CNT_W-1:0] step_count;
    logic             bp_hit;
    logic             disp_refresh;
    logic [1:0]       ctrl_state;

    modport master (
        output key_step_n, key_run_n, manual_mode,
        output bp_en, bp_pc, pc_fetch, cpu_halt,
        input  cpu_en, step_count, bp_hit,
        input  disp_refresh, ctrl_state
    );

    modport slave (
        input  key_step_n, key_run_n, manual_mode,
        input  bp_en, bp_pc, pc_fetch, cpu_halt,
        output cpu_en, step_count, bp_hit,
        output disp_refresh, ctrl_state
    );
endinterface

// File: rtl/debug_step_controller.sv
// Step/run/free-run clock-enable sequencer for the pipelined CPU.
// Define DEBUG_BREAKPOINT_EN to build the fetch-PC breakpoint logic.
module debug_step_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    debug_step_controller_if.slave dbg
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Bit 0 is the STEP key, bit 1 the RUN/STOP key.
    logic [1:0]    key_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_prev_q;
    logic [1:0]    press_q;
    logic [DW-1:0] db_cnt_q [2];
    logic          step_press;
    logic          run_press;

    assign key_raw    = {dbg.key_run_n, dbg.key_step_n};
    assign step_press = press_q[0];
    assign run_press  = press_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            db_q        <= '1;
            db_prev_q   <= '1;
            press_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            press_q   <= db_prev_q & ~db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    state_t           state_q;
    state_t           state_d;
    logic             cpu_en;
    logic             bp_match;
    logic             refresh_q;
    logic             refresh_d;
    logic [CNT_W-1:0] cnt_q;

    assign cpu_en = (state_q == STEP)
                  | ((state_q == RUN) & ~bp_match);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!dbg.manual_mode)  state_d = RUN;
                else if (run_press)    state_d = RUN;
                else if (step_press)   state_d = STEP;
            end
            STEP: state_d = IDLE;
            RUN: begin
                if (dbg.manual_mode && run_press) state_d = IDLE;
                else if (bp_match)                state_d = IDLE;
            end
            HALTED: state_d = HALTED;
        endcase
        if (dbg.cpu_halt && cpu_en) state_d = HALTED;
        refresh_d = ((state_q == STEP) && (state_d == IDLE))
                  | ((state_q == RUN) && (state_d != RUN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            refresh_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
            if (cpu_en && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef DEBUG_BREAKPOINT_EN
    logic bp_skip_q;
    logic bp_hit_q;

    // Skip lets a resume start fetching from the PC we stopped on.
    assign bp_match = dbg.manual_mode & dbg.bp_en
                    & (dbg.pc_fetch == dbg.bp_pc) & ~bp_skip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && (state_d != IDLE))
                bp_skip_q <= 1'b1;
            else if (cpu_en)
                bp_skip_q <= 1'b0;
            if ((state_q == RUN) && bp_match)
                bp_hit_q <= 1'b1;
            else if ((state_q == IDLE) && dbg.manual_mode
                     && (step_press || run_press))
                bp_hit_q <= 1'b0;
        end
    end

    assign dbg.bp_hit = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp  = &{1'b0, dbg.bp_en, dbg.bp_pc, dbg.pc_fetch};
    assign bp_match   = 1'b0;
    assign dbg.bp_hit = 1'b0;
`endif

    assign dbg.cpu_en       = cpu_en;
    assign dbg.step_count   = cnt_q;
    assign dbg.disp_refresh = refresh_q;
    assign dbg.ctrl_state   = state_q;
endmodule

// File: tb/tb_debug_step_controller.sv
// Scoreboard bench for debug_step_controller: directed button, halt,
// breakpoint and free-run vectors, checked cycle by cycle.
module tb_debug_step_controller;
    logic clk;
    logic rst_n;

    debug_step_controller_if #(.CNT_W(4)) dbg ();

    debug_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dbg(dbg)
    );

    typedef struct {
        int    cyc;
        int    st;
        int    en;
        int    cnt;
        int    hit;
        int    rf;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   c0 = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc
                || int'(dbg.ctrl_state) != e.st
                || int'(dbg.cpu_en) != e.en
                || int'(dbg.step_count) != e.cnt
                || int'(dbg.bp_hit) != e.hit
                || int'(dbg.disp_refresh) != e.rf) begin
                n_bad++;
                $display("FAIL %s cyc %0d/%0d: got st=%0d en=%0d cnt=%0d hit=%0d rf=%0d, want st=%0d en=%0d cnt=%0d hit=%0d rf=%0d",
                         e.nm, cyc, e.cyc, dbg.ctrl_state, dbg.cpu_en,
                         dbg.step_count, dbg.bp_hit, dbg.disp_refresh,
                         e.st, e.en, e.cnt, e.hit, e.rf);
            end
        end
    end

    task automatic chk(input int k, input int st, input int en,
                       input int cnt, input int hit, input int rf,
                       input string nm);
        exp_t e;
        e = '{c0 + k, st, en, cnt, hit, rf, nm};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic man);
        exp_t e;
        rst_n           = 1'b0;
        dbg.key_step_n  = 1'b1;
        dbg.key_run_n   = 1'b1;
        dbg.manual_mode = man;
        dbg.cpu_halt    = 1'b0;
        #1;
        e = '{cyc, 0, 0, 0, 0, 0, "reset"};
        sb.push_back(e);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        dbg.key_step_n  = 1'b1;
        dbg.key_run_n   = 1'b1;
        dbg.manual_mode = 1'b1;
        dbg.bp_en       = 1'b0;
        dbg.bp_pc       = 7'd0;
        dbg.pc_fetch    = 7'd0;
        dbg.cpu_halt    = 1'b0;
        tick();

        // Single step with a bounce, then held low.
        apply_reset(1'b1);
        c0 = cyc;
        chk(9,  0, 0, 0, 0, 0, "step_wait");
        chk(10, 1, 1, 0, 0, 0, "step_on");
        chk(11, 0, 0, 1, 0, 1, "step_refresh");
        chk(12, 0, 0, 1, 0, 0, "step_done");
        chk(25, 0, 0, 1, 0, 0, "step_hold");
        for (int k = 0; k < 28; k++) begin
            dbg.key_step_n = (k == 1);
            tick();
        end

        // Both presses in the same IDLE cycle, then reset mid-run.
        apply_reset(1'b1);
        c0 = cyc;
        chk(7, 0, 0, 0, 0, 0, "simul_wait");
        chk(8, 2, 1, 0, 0, 0, "simul_run");
        chk(9, 2, 1, 1, 0, 0, "simul_run2");
        for (int k = 0; k < 10; k++) begin
            dbg.key_step_n = 1'b0;
            dbg.key_run_n  = 1'b0;
            tick();
        end

        // Halt from RUN; later presses must not leave HALTED.
        apply_reset(1'b1);
        c0 = cyc;
        chk(8,  2, 1, 0, 0, 0, "halt_run");
        chk(10, 2, 1, 2, 0, 0, "halt_pre");
        chk(11, 3, 0, 3, 0, 1, "halt_enter");
        chk(12, 3, 0, 3, 0, 0, "halt_stay");
        chk(30, 3, 0, 3, 0, 0, "halt_presses");
        for (int k = 0; k < 32; k++) begin
            dbg.key_run_n  = !(k < 11 || k >= 18);
            dbg.key_step_n = !(k >= 11);
            dbg.cpu_halt   = (k == 10);
            tick();
        end
        apply_reset(1'b1);
        c0 = cyc;
        chk(1, 0, 0, 0, 0, 0, "post_reset_idle");
        tick();
        tick();
        tick();

        apply_reset(1'b1);
        dbg.bp_en = 1'b1;
        dbg.bp_pc = 7'd12;
        c0 = cyc;
`ifdef DEBUG_BREAKPOINT_EN
        chk(7,  0, 0, 0, 0, 0, "bp_wait");
        chk(8,  2, 1, 0, 0, 0, "bp_run");
        chk(11, 2, 1, 3, 0, 0, "bp_pc11");
        chk(12, 2, 0, 4, 0, 0, "bp_stop");
        chk(13, 0, 0, 4, 1, 1, "bp_idle");
        chk(14, 0, 0, 4, 1, 0, "bp_idle2");
        chk(27, 0, 0, 4, 1, 0, "bp_before_resume");
        chk(28, 2, 1, 4, 0, 0, "bp_resume");
        chk(29, 2, 1, 5, 0, 0, "bp_pc13");
        chk(31, 2, 1, 7, 0, 0, "bp_pc15");
        for (int k = 0; k < 33; k++) begin
            dbg.key_run_n = !(k <= 12 || k >= 20);
            if (k < 8)        dbg.pc_fetch = 7'd0;
            else if (k <= 12) dbg.pc_fetch = 7'(k);
            else if (k < 29)  dbg.pc_fetch = 7'd12;
            else              dbg.pc_fetch = 7'(k - 16);
            tick();
        end
`else
        chk(8,  2, 1, 0, 0, 0, "nobp_run");
        chk(12, 2, 1, 4, 0, 0, "nobp_match");
        chk(13, 2, 1, 5, 0, 0, "nobp_keep");
        for (int k = 0; k < 15; k++) begin
            dbg.key_run_n = 1'b0;
            dbg.pc_fetch  = 7'd12;
            tick();
        end
`endif

        // Free-run: breakpoint matches are ignored; counter saturates.
        dbg.bp_en    = 1'b1;
        dbg.bp_pc    = 7'd12;
        dbg.pc_fetch = 7'd12;
        apply_reset(1'b0);
        c0 = cyc;
        chk(0,  0, 0, 0,  0, 0, "free_idle");
        chk(1,  2, 1, 0,  0, 0, "free_run");
        chk(5,  2, 1, 4,  0, 0, "free_cnt4");
        chk(15, 2, 1, 14, 0, 0, "free_cnt14");
        chk(16, 2, 1, 15, 0, 0, "free_sat");
        chk(25, 2, 1, 15, 0, 0, "free_sat_hold");
        for (int k = 0; k < 27; k++) tick();

        tick();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0",
                     sb.size());
            n_bad += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
